// File: rtl/joy_serial_scanner_if.sv
// Pin-side and status bundle of the serial joystick scanner.
// The master side is the scanner: it drives the chain clock and load strobe,
// receives the serial data and publishes the debounced button state.
interface joy_serial_scanner_if #(
  parameter int WIDTH = 24
);
  logic             joy_data;
  logic             joy_clk;
  logic             joy_load;
  logic [WIDTH-1:0] joy_out;
  logic             frame_done;
  logic             joy_changed;

  modport master (
    input  joy_data,
    output joy_clk,
    output joy_load,
    output joy_out,
    output frame_done,
    output joy_changed
  );

  modport slave (
    output joy_data,
    input  joy_clk,
    input  joy_load,
    input  joy_out,
    input  frame_done,
    input  joy_changed
  );
endinterface

// File: rtl/joy_serial_scanner.sv
// Serial joystick scanner: clocks a PISO shift-register chain, deserialises
// NUM_PORTS x BITS_PER_PORT active-low button bits per frame and only commits
// a frame to joy_out after DEBOUNCE_FRAMES consecutive identical frames.
module joy_serial_scanner #(
  parameter int DIV_LOG2        = 3,
  parameter int NUM_PORTS       = 2,
  parameter int BITS_PER_PORT   = 12,
  parameter int LEAD_BITS       = 2,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  joy_serial_scanner_if.master   bus
);
  localparam int TOTAL     = NUM_PORTS * BITS_PER_PORT;
  localparam int FRAME_LEN = 1 + LEAD_BITS + TOTAL;
  localparam int DW        = DIV_LOG2 + 1;
  localparam int CW        = $clog2(FRAME_LEN);

  // The tick fires when the divider sits just below its MSB flip, i.e. on the
  // clk edge that raises joy_clk.
  localparam logic [DW-1:0] TICK_VAL   = {1'b0, {DIV_LOG2{1'b1}}};
  localparam logic [CW-1:0] LAST_SLOT  = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] FIRST_DATA = CW'(1 + LEAD_BITS);
  localparam logic [3:0]    MATCH_MAX  = 4'(DEBOUNCE_FRAMES - 1);

  logic [DW-1:0]    div;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    bit_idx;
  logic             tick;
  logic             load_q;
  logic [TOTAL-1:0] raw;
  logic [TOTAL-1:0] prev;
  logic [TOTAL-1:0] out_q;
  logic [3:0]       match;
  logic [3:0]       match_next;
  logic             frame_end;
  logic             done_q;
  logic             changed_q;

  assign tick             = (div == TICK_VAL);
  assign bus.joy_clk      = div[DW-1];
  assign bus.joy_load     = load_q;
  assign bus.joy_out      = out_q;
  assign bus.frame_done   = done_q;
  assign bus.joy_changed  = changed_q;

  // Next slot number, the raw bit a data slot lands in, and the debounce count
  // the frame currently held in raw would produce.
  always_comb begin
    cnt_next   = (cnt == LAST_SLOT) ? '0 : cnt + 1'b1;
    bit_idx    = LAST_SLOT - cnt;
    match_next = '0;
    if (raw == prev) begin
      match_next = (match == MATCH_MAX) ? MATCH_MAX : match + 1'b1;
    end
  end

  // Free-running divider, slot counter and load strobe; data slots shift the
  // serial bit into raw with the first bit of the frame landing in the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      div       <= '0;
      cnt       <= '0;
      load_q    <= 1'b0;
      raw       <= '1;
      frame_end <= 1'b0;
    end else begin
      div       <= div + 1'b1;
      frame_end <= tick && (cnt == LAST_SLOT);
      if (tick) begin
        cnt    <= cnt_next;
        load_q <= (cnt_next != '0);
        for (int i = 0; i < TOTAL; i++) begin
          if ((cnt >= FIRST_DATA) && (bit_idx == CW'(i))) begin
            raw[i] <= bus.joy_data;
          end
        end
      end
    end
  end

  // One clk after the last data sample: compare with the previous frame,
  // update the agreement count and commit once enough frames agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev      <= '1;
      out_q     <= '1;
      match     <= '0;
      done_q    <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      done_q    <= frame_end;
      changed_q <= 1'b0;
      if (frame_end) begin
        prev  <= raw;
        match <= match_next;
        if (match_next == MATCH_MAX) begin
          out_q     <= raw;
          changed_q <= (raw != out_q);
        end
      end
    end
  end
endmodule

// File: tb/tb_joy_serial_scanner.sv
// Scoreboard bench for joy_serial_scanner: three instances (default geometry,
// a small fast single-port chain, and a three-frame debounce) each fed by a
// PISO shift-register model; expected per-frame results are queued by the
// stimulus and checked by monitors on every frame_done.
module tb_joy_serial_scanner;
  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  logic reset_c = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // 10 ns system clock and a cycle counter for period measurements.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  joy_serial_scanner_if #(.WIDTH(24)) if_a ();
  joy_serial_scanner_if #(.WIDTH(8))  if_b ();
  joy_serial_scanner_if #(.WIDTH(24)) if_c ();

  joy_serial_scanner dut_a (.clk(clk), .reset(reset_a), .bus(if_a));

  joy_serial_scanner #(
    .DIV_LOG2(1), .NUM_PORTS(1), .BITS_PER_PORT(8), .LEAD_BITS(0), .DEBOUNCE_FRAMES(1)
  ) dut_b (.clk(clk), .reset(reset_b), .bus(if_b));

  joy_serial_scanner #(.DEBOUNCE_FRAMES(3)) dut_c (.clk(clk), .reset(reset_c), .bus(if_c));

  // Patterns presented at the parallel inputs of each chain.
  logic [23:0] pat_a = 24'hFFFFFF;
  logic [7:0]  pat_b = 8'hFF;
  logic [23:0] pat_c = 24'hFFFFFF;

  // Expected {joy_changed, joy_out} per frame, in frame order.
  logic [32:0] q_a[$];
  logic [32:0] q_b[$];
  logic [32:0] q_c[$];
  logic active_a = 1'b1;
  logic active_b = 1'b1;
  logic active_c = 1'b1;

  // Shift-register models: parallel load while load is low, shift on a rising
  // joy_clk only once load was already high before that edge.
  logic [25:0] sr_a = '1;
  logic [7:0]  sr_b = '1;
  logic [25:0] sr_c = '1;
  logic pj_a = 1'b0, pl_a = 1'b0, pj_b = 1'b0, pl_b = 1'b0, pj_c = 1'b0, pl_c = 1'b0;

  always @(negedge clk) begin
    if (!if_a.joy_load) sr_a = {2'b11, pat_a};
    else if (if_a.joy_clk && !pj_a && pl_a) sr_a = {sr_a[24:0], 1'b1};
    if_a.joy_data = sr_a[25];
    pj_a = if_a.joy_clk;
    pl_a = if_a.joy_load;
    if (!if_b.joy_load) sr_b = pat_b;
    else if (if_b.joy_clk && !pj_b && pl_b) sr_b = {sr_b[6:0], 1'b1};
    if_b.joy_data = sr_b[7];
    pj_b = if_b.joy_clk;
    pl_b = if_b.joy_load;
    if (!if_c.joy_load) sr_c = {2'b11, pat_c};
    else if (if_c.joy_clk && !pj_c && pl_c) sr_c = {sr_c[24:0], 1'b1};
    if_c.joy_data = sr_c[25];
    pj_c = if_c.joy_clk;
    pl_c = if_c.joy_load;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    n_checks++;
    n_errors++;
    $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic logic load_of(input int sel);
    case (sel)
      0:       return if_a.joy_load;
      1:       return if_b.joy_load;
      default: return if_c.joy_load;
    endcase
  endfunction

  function automatic int qsize(input int sel);
    case (sel)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  // Waits for the next load window, presents the pattern for that frame and
  // queues what the frame should produce.
  task automatic applyStimulus(input int sel, input logic [23:0] pattern,
                               input logic [23:0] exp_out, input logic exp_ch);
    int n;
    n = 0;
    while (load_of(sel) !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin failNow("load_wait"); return; end
    case (sel)
      0:       begin pat_a = pattern;      q_a.push_back({exp_ch, 8'h00, exp_out}); end
      1:       begin pat_b = pattern[7:0]; q_b.push_back({exp_ch, 8'h00, exp_out}); end
      default: begin pat_c = pattern;      q_c.push_back({exp_ch, 8'h00, exp_out}); end
    endcase
    n = 0;
    while (load_of(sel) === 1'b0 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) failNow("load_release");
  endtask

  task automatic waitDrain(input int sel);
    int n;
    n = 0;
    while (qsize(sel) != 0 && n < 3000) begin @(negedge clk); n++; end
    checkOutput("queue_drained", 32'(qsize(sel)), 32'd0);
    case (sel)
      0:       active_a = 1'b0;
      1:       active_b = 1'b0;
      default: active_c = 1'b0;
    endcase
  endtask

  // Starts an all-zero frame on instance A and resets it about 15 ticks in.
  task automatic midFrameReset();
    int n;
    logic pj;
    n = 0;
    while (if_a.joy_load !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    pat_a = 24'h000000;
    while (if_a.joy_load === 1'b0 && n < 6000) begin @(negedge clk); n++; end
    if (n >= 6000) begin failNow("mid_reset_sync"); return; end
    pj = if_a.joy_clk;
    for (int t = 0; t < 14; t++) begin
      n = 0;
      do begin pj = if_a.joy_clk; @(negedge clk); n++; end
      while (!(if_a.joy_clk && !pj) && n < 100);
    end
    reset_a = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midreset_joy_out", 32'(if_a.joy_out), 32'h00FFFFFF);
    checkOutput("midreset_joy_load", 32'(if_a.joy_load), 32'd0);
    checkOutput("midreset_frame_done", 32'(if_a.frame_done), 32'd0);
    reset_a = 1'b0;
    @(negedge clk);
    checkOutput("restart_with_load", 32'(if_a.joy_load), 32'd0);
  endtask

  // Instance A monitor: scoreboard on frame_done plus load-width, joy_clk
  // period, frame period and strobe-coincidence checks.
  int a_low = 0, a_last_fd = -1, a_last_jc = -1;
  logic a_skip = 1'b1, a_pl = 1'b0, a_pj = 1'b0;
  logic [32:0] a_exp;
  always @(negedge clk) begin
    if (reset_a) begin
      a_low = 0; a_last_fd = -1; a_last_jc = -1; a_skip = 1'b1;
    end else begin
      if (!if_a.joy_load) a_low++;
      else begin
        if (!a_pl && !a_skip) checkOutput("load_low_clks", 32'(a_low), 32'd16);
        if (!a_pl) a_skip = 1'b0;
        a_low = 0;
      end
      if (if_a.joy_clk && !a_pj) begin
        if (a_last_jc >= 0) checkOutput("joy_clk_period", 32'(cyc - a_last_jc), 32'd16);
        a_last_jc = cyc;
      end
      if (if_a.joy_changed && !if_a.frame_done) checkOutput("a_changed_alone", 32'd1, 32'd0);
      if (if_a.frame_done && active_a) begin
        if (a_last_fd >= 0) checkOutput("a_frame_period", 32'(cyc - a_last_fd), 32'd432);
        a_last_fd = cyc;
        if (q_a.size() == 0) checkOutput("a_unexpected_frame", 32'd1, 32'd0);
        else begin
          a_exp = q_a.pop_front();
          checkOutput("a_joy_out", 32'(if_a.joy_out), a_exp[31:0]);
          checkOutput("a_joy_changed", 32'(if_a.joy_changed), 32'(a_exp[32]));
        end
      end
    end
    a_pl = if_a.joy_load;
    a_pj = if_a.joy_clk;
  end

  // Instance B monitor: scoreboard and 36-clk frame period.
  int b_last_fd = -1;
  logic [32:0] b_exp;
  always @(negedge clk) begin
    if (reset_b) b_last_fd = -1;
    else begin
      if (if_b.joy_changed && !if_b.frame_done) checkOutput("b_changed_alone", 32'd1, 32'd0);
      if (if_b.frame_done && active_b) begin
        if (b_last_fd >= 0) checkOutput("b_frame_period", 32'(cyc - b_last_fd), 32'd36);
        b_last_fd = cyc;
        if (q_b.size() == 0) checkOutput("b_unexpected_frame", 32'd1, 32'd0);
        else begin
          b_exp = q_b.pop_front();
          checkOutput("b_joy_out", 32'(if_b.joy_out), b_exp[31:0]);
          checkOutput("b_joy_changed", 32'(if_b.joy_changed), 32'(b_exp[32]));
        end
      end
    end
  end

  // Instance C monitor: scoreboard and 432-clk frame period.
  int c_last_fd = -1;
  logic [32:0] c_exp;
  always @(negedge clk) begin
    if (reset_c) c_last_fd = -1;
    else begin
      if (if_c.joy_changed && !if_c.frame_done) checkOutput("c_changed_alone", 32'd1, 32'd0);
      if (if_c.frame_done && active_c) begin
        if (c_last_fd >= 0) checkOutput("c_frame_period", 32'(cyc - c_last_fd), 32'd432);
        c_last_fd = cyc;
        if (q_c.size() == 0) checkOutput("c_unexpected_frame", 32'd1, 32'd0);
        else begin
          c_exp = q_c.pop_front();
          checkOutput("c_joy_out", 32'(if_c.joy_out), c_exp[31:0]);
          checkOutput("c_joy_changed", 32'(if_c.joy_changed), 32'(c_exp[32]));
        end
      end
    end
  end

  // Overall run bound.
  initial begin
    repeat (60000) @(posedge clk);
    n_errors++;
    $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Reset state, then the three scenario threads in parallel.
  initial begin
    repeat (4) @(negedge clk);
    checkOutput("rst_a_joy_out", 32'(if_a.joy_out), 32'h00FFFFFF);
    checkOutput("rst_a_joy_load", 32'(if_a.joy_load), 32'd0);
    checkOutput("rst_a_joy_clk", 32'(if_a.joy_clk), 32'd0);
    checkOutput("rst_a_frame_done", 32'(if_a.frame_done), 32'd0);
    checkOutput("rst_a_joy_changed", 32'(if_a.joy_changed), 32'd0);
    checkOutput("rst_b_joy_out", 32'(if_b.joy_out), 32'h000000FF);
    checkOutput("rst_c_joy_out", 32'(if_c.joy_out), 32'h00FFFFFF);
    reset_a = 1'b0;
    reset_b = 1'b0;
    reset_c = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) applyStimulus(0, 24'hFFFFFF, 24'hFFFFFF, 1'b0);
        applyStimulus(0, 24'hFFFFFE, 24'hFFFFFF, 1'b0);
        applyStimulus(0, 24'hFFFFFE, 24'hFFFFFE, 1'b1);
        applyStimulus(0, 24'hFFFFFE, 24'hFFFFFE, 1'b0);
        applyStimulus(0, 24'hFFFFFF, 24'hFFFFFE, 1'b0);
        applyStimulus(0, 24'hFFFFFF, 24'hFFFFFF, 1'b1);
        applyStimulus(0, 24'hFFF7FF, 24'hFFFFFF, 1'b0);
        applyStimulus(0, 24'hFFFFFF, 24'hFFFFFF, 1'b0);
        applyStimulus(0, 24'hFFFFFF, 24'hFFFFFF, 1'b0);
        midFrameReset();
        applyStimulus(0, 24'h000000, 24'hFFFFFF, 1'b0);
        applyStimulus(0, 24'h000000, 24'h000000, 1'b1);
        applyStimulus(0, 24'h000000, 24'h000000, 1'b0);
        waitDrain(0);
      end
      begin
        applyStimulus(1, 24'h0000A5, 24'h0000A5, 1'b1);
        applyStimulus(1, 24'h00003C, 24'h00003C, 1'b1);
        applyStimulus(1, 24'h00003C, 24'h00003C, 1'b0);
        applyStimulus(1, 24'h0000FF, 24'h0000FF, 1'b1);
        waitDrain(1);
      end
      begin
        applyStimulus(2, 24'h000001, 24'hFFFFFF, 1'b0);
        applyStimulus(2, 24'h000002, 24'hFFFFFF, 1'b0);
        applyStimulus(2, 24'h000001, 24'hFFFFFF, 1'b0);
        applyStimulus(2, 24'h000002, 24'hFFFFFF, 1'b0);
        applyStimulus(2, 24'h000002, 24'hFFFFFF, 1'b0);
        applyStimulus(2, 24'h000002, 24'h000002, 1'b1);
        waitDrain(2);
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/joy_serial_scanner.md
# joy_serial_scanner

Parametrised serial joystick scanner. It drives the clock and load strobe of an external parallel-in/serial-out shift-register chain, and deserialises frames of NUM_PORTS × BITS_PER_PORT active-low button bits. Each frame is debounced by requiring consecutive identical frames before it updates the outputs. It sits between the joystick connector pins and the joystick mapping logic, and is the generalised successor of the fixed two-player, 12-bit decoder, adding configurable geometry, a synchronous reset, frame-agreement filtering and status strobes.

## Interface
- DIV_LOG2, 3: shift-clock divider; joy_clk period = 2^(DIV_LOG2+1) clk cycles (min 1)
- NUM_PORTS, 2: joysticks in the chain (1..4)
- BITS_PER_PORT, 12: bits per joystick (1..16)
- LEAD_BITS, 2: serial bits discarded after load, before port data (0..7)
- DEBOUNCE_FRAMES, 2: consecutive identical frames required to commit (1..15)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- joy_data  in  1  serial data from chain, active-low buttons
- joy_clk  out  1  shift clock to chain
- joy_load  out  1  parallel load, active-low
- joy_out  out  NUM_PORTS*BITS_PER_PORT  committed button state; port p occupies bits [p*BITS_PER_PORT +: BITS_PER_PORT]; 1 = released
- frame_done  out  1  one-clk pulse per completed frame
- joy_changed  out  1  one-clk pulse when joy_out takes a different value

## Operation
- TOTAL = NUM_PORTS*BITS_PER_PORT. FRAME_LEN = 1 + LEAD_BITS + TOTAL shift ticks.
- Divider: a free-running counter div of width DIV_LOG2+1. joy_clk = div MSB.
- tick is asserted in the clk cycle where div = 0 followed by all ones, i.e. the edge on which joy_clk rises.
- Slot counter cnt runs 0..FRAME_LEN-1 and advances on each tick, wrapping to 0 after FRAME_LEN-1.
- joy_load is registered and updated on tick: it is 0 while cnt = 0, and 1 otherwise.
- Sampling: on a tick with cnt = 1+LEAD_BITS+k (k = 0..TOTAL-1), joy_data is stored into raw[TOTAL-1-k], so the first data bit lands in the MSB.
  - Lead slots and the load slot sample nothing.
  - joy_data is sampled directly, with no synchroniser; it has been stable for one full joy_clk period.
- Frame end is the tick that samples k = TOTAL-1. On the following clk edge:
  - frame_done = 1 for one cycle.
  - The completed frame F is compared with the previous frame P.
  - If F == P, match saturates upward to DEBOUNCE_FRAMES-1; otherwise match = 0.
  - P is then set to F.
  - Commit happens if (new match) ≥ DEBOUNCE_FRAMES-1: joy_out = F. joy_changed = 1 if F differs from the old joy_out.
  - DEBOUNCE_FRAMES = 1 therefore commits every frame.
- A frame is never partially committed; joy_out changes only at a frame end.

## Timing
- Reset (synchronous, sampled on clk):
  - div = 0, cnt = 0, joy_clk = 0, joy_load = 0.
  - raw, P and joy_out = all ones; match = 0.
  - frame_done = 0, joy_changed = 0.
- Reset asserted mid-frame discards the partial frame and the debounce history. The first frame after reset starts with the load slot.
- Tick spacing: exactly 2^(DIV_LOG2+1) clk. Frame period: FRAME_LEN ticks. With defaults: 16 clk per tick, 27 ticks, 432 clk.
- Latency: the last data sample to frame_done and the joy_out update is 1 clk.
- A new stable input shows on joy_out at the end of the DEBOUNCE_FRAMES-th frame that fully contains it.
- frame_done and joy_changed are coincident when both assert. Neither lasts more than 1 clk.
- A glitch shorter than one frame never reaches joy_out when DEBOUNCE_FRAMES ≥ 2.

## Test plan
- Reset, hold joy_data = 1, defaults:
  - joy_load is low for exactly 1 tick of every 27; joy_clk period is 16 clk.
  - frame_done pulses every 432 clk; joy_out stays 0xFFFFFF; joy_changed never pulses.
- Shift-register model presenting 0xFFFFFE (port 0 bit 0 pressed), defaults:
  - joy_out = 0xFFFFFE after the 2nd frame_done; joy_changed pulses once.
- Single-frame glitch 0xFFF7FF between all-ones frames, DEBOUNCE_FRAMES = 2:
  - joy_out never leaves 0xFFFFFF.
- DEBOUNCE_FRAMES = 1, NUM_PORTS = 1, BITS_PER_PORT = 8, LEAD_BITS = 0, DIV_LOG2 = 1:
  - Pattern 0xA5 appears after the first frame; frame = 9 ticks × 4 clk = 36 clk.
- Assert reset at tick 15 of a frame while data is 0x000000:
  - joy_out stays 0xFFFFFF and the frame restarts with load.
  - Two full all-zero frames then give joy_out = 0x000000.
- Alternating 0x000001 and 0x000002 every frame, DEBOUNCE_FRAMES = 3:
  - No commit occurs; match stays 0; joy_out holds its prior value.
